// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data-memory responder with programmable wait states.
module data_mem_responder #(
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, be_q, be_d;
  logic we_q, we_d, err_q, err_d, bad, access;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, word;
  logic [ADDR_W-1:0] idx;
  logic [31:0] mem [2**ADDR_W];
  assign idx = addr_q[ADDR_W+1:2];
  assign bad = (addr_q[1:0] != 2'b0) || (addr_q[31:ADDR_W+2] != '0);
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign req_ready = (state_q == IDLE) && !RST;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  // Loads see the stored word; stores see it with the enabled lanes replaced.
  always_comb begin
    word = mem[idx];
    for (int i = 0; i < 4; i++)
      if (we_q && be_q[i]) word[8*i+:8] = wdata_q[8*i+:8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    be_d = be_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = WAIT;
        cnt_d = 4'(LATENCY);
        we_d = req_we;
        be_d = req_be;
        addr_d = req_addr;
        wdata_d = req_wdata;
      end
      WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = RESP;
        rdata_d = bad ? '0 : word;
        err_d = bad;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (access && we_q && !bad) mem[idx] <= word;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of three responders (LATENCY 2, 0 and 15).
module tb_data_mem_responder;
  logic CLK = 1'b0, RST = 1'b1, we_i = 1'b0;
  logic [3:0] be_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic v [3];
  logic rr [3];
  logic rv [3];
  logic er [3];
  logic [31:0] rd [3];
  int n_cmp = 0, n_bad = 0;
  always #5 CLK = ~CLK;
  data_mem_responder #(.ADDR_W(7), .LATENCY(2)) u0 (.CLK(CLK), .RST(RST), .req_valid(v[0]), .req_ready(rr[0]),
    .req_we(we_i), .req_be(be_i), .req_addr(addr_i), .req_wdata(wdata_i), .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]));
  data_mem_responder #(.ADDR_W(7), .LATENCY(0)) u1 (.CLK(CLK), .RST(RST), .req_valid(v[1]), .req_ready(rr[1]),
    .req_we(we_i), .req_be(be_i), .req_addr(addr_i), .req_wdata(wdata_i), .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]));
  data_mem_responder #(.ADDR_W(7), .LATENCY(15)) u2 (.CLK(CLK), .RST(RST), .req_valid(v[2]), .req_ready(rr[2]),
    .req_we(we_i), .req_be(be_i), .req_addr(addr_i), .req_wdata(wdata_i), .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(er[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Issues one request on instance k and counts edges from accept to visible rsp_valid.
  task automatic txn(input int k, input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                     output int n, output logic [31:0] d, output logic e);
    @(negedge CLK);
    we_i = we;
    be_i = be;
    addr_i = a;
    wdata_i = wd;
    v[k] = 1'b1;
    @(posedge CLK);
    #1 v[k] = 1'b0;
    n = 0;
    do begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end while (!rv[k] && n < 40);
    d = rd[k];
    e = er[k];
  endtask
  initial begin
    int n, rdy_cnt, pls_cnt, first_rdy, second_rdy, overlap;
    logic [31:0] d;
    logic e;
    for (int k = 0; k < 3; k++) v[k] = 1'b0;
    #12;
    chk("rst_ready", 32'(rr[0]), 32'd0);
    chk("rst_valid", 32'(rv[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'd0);
    chk("rst_err", 32'(er[0]), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", 32'(rr[0]), 32'd1);
    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, n, d, e);
    chk("st10_lat", 32'(n), 32'd3);
    chk("st10_rdata", d, 32'hDEADBEEF);
    chk("st10_err", 32'(e), 32'd0);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, n, d, e);
    chk("ld10_lat", 32'(n), 32'd3);
    chk("ld10_rdata", d, 32'hDEADBEEF);
    chk("ld10_err", 32'(e), 32'd0);
    txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344, n, d, e);
    txn(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, n, d, e);
    chk("be0101_rdata", d, 32'h11BB33DD);
    txn(0, 1'b0, 4'h0, 32'h20, 32'h0, n, d, e);
    chk("ld20_rdata", d, 32'h11BB33DD);
    txn(0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, n, d, e);
    chk("be0_rdata", d, 32'hDEADBEEF);
    chk("be0_err", 32'(e), 32'd0);
    txn(0, 1'b0, 4'h0, 32'h22, 32'h0, n, d, e);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_rdata", d, 32'd0);
    txn(0, 1'b1, 4'hF, 32'h0, 32'h5A5A5A5A, n, d, e);
    txn(0, 1'b1, 4'hF, 32'h200, 32'h01020304, n, d, e);
    chk("oor_err", 32'(e), 32'd1);
    chk("oor_rdata", d, 32'd0);
    txn(0, 1'b0, 4'h0, 32'h0, 32'h0, n, d, e);
    chk("word0_kept", d, 32'h5A5A5A5A);
    chk("word0_err", 32'(e), 32'd0);
    // req_valid held high: accepts every LATENCY+3 edges, one pulse each.
    @(negedge CLK);
    we_i = 1'b0;
    addr_i = 32'h10;
    v[0] = 1'b1;
    rdy_cnt = 0;
    pls_cnt = 0;
    first_rdy = 0;
    second_rdy = 0;
    overlap = 0;
    for (int k = 1; k <= 20; k++) begin
      if (rr[0]) begin
        rdy_cnt++;
        if (rdy_cnt == 1) first_rdy = k;
        if (rdy_cnt == 2) second_rdy = k;
      end
      if (rv[0]) pls_cnt++;
      if (rr[0] && rv[0]) overlap++;
      if (k == 20) v[0] = 1'b0;
      @(negedge CLK);
    end
    chk("hs_accepts", 32'(rdy_cnt), 32'd4);
    chk("hs_pulses", 32'(pls_cnt), 32'd4);
    chk("hs_spacing", 32'(second_rdy - first_rdy), 32'd5);
    chk("hs_overlap", 32'(overlap), 32'd0);
    we_i = 1'b1;
    be_i = 4'hF;
    addr_i = 32'h10;
    wdata_i = 32'h12345678;
    v[0] = 1'b1;
    @(posedge CLK);
    #1 v[0] = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort_valid", 32'(rv[0]), 32'd0);
    chk("abort_rdata", rd[0], 32'd0);
    chk("abort_err", 32'(er[0]), 32'd0);
    chk("abort_ready", 32'(rr[0]), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, n, d, e);
    chk("abort_old_data", d, 32'hDEADBEEF);
    txn(1, 1'b1, 4'hF, 32'h4, 32'hCAFEF00D, n, d, e);
    chk("l0_st_lat", 32'(n), 32'd1);
    chk("l0_st_rdata", d, 32'hCAFEF00D);
    txn(1, 1'b0, 4'h0, 32'h4, 32'h0, n, d, e);
    chk("l0_ld_lat", 32'(n), 32'd1);
    chk("l0_ld_rdata", d, 32'hCAFEF00D);
    txn(2, 1'b1, 4'hF, 32'h8, 32'h0BADF00D, n, d, e);
    chk("l15_st_lat", 32'(n), 32'd16);
    txn(2, 1'b0, 4'h0, 32'h8, 32'h0, n, d, e);
    chk("l15_ld_lat", 32'(n), 32'd16);
    chk("l15_ld_rdata", d, 32'h0BADF00D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
